// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// nibble_serial_add_ctrl: WIDTH-bit add/subtract sequenced through one 4-bit CLA slice
// Revision 1.0 - initial release
// ============================================================================

module adder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s    = p ^ c[3:0];
  assign co   = c[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic [CW+1:0]    base;
  logic             carry;
  logic             cout_q;
  logic             last;
  logic [3:0]       nib_s;
  logic             nib_co;

  assign base = {cnt, 2'b00};
  assign last = (cnt == LAST);

  adder_4bits u_slice (
    .a  (a_q[base +: 4]),
    .b  (b_q[base +: 4]),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (in_valid)  state_next = RUN;
        RUN:     if (last)      state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Subtraction is folded in at accept time: B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (flush) begin
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= op_a;
            b_q   <= sub ? ~op_b : op_b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_q[base +: 4] <= nib_s;
          carry            <= nib_co;
          if (last) begin
            cout_q <= nib_co;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = sum_q;
  assign cout      = cout_q;
  assign ovf       = out_valid && (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
  assign zero      = out_valid && (sum_q == '0);
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=32 and WIDTH=8 instances).
`timescale 1ns/1ps

module tb_nibble_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        flush = 1'b0, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [31:0] result;

  logic        in_valid8 = 1'b0, sub8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0]  op_a8 = '0, op_b8 = '0;
  logic        in_ready8, out_valid8, cout8, ovf8, zero8;
  logic [7:0]  result8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  nibble_serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in_valid8), .in_ready(in_ready8),
    .op_a(op_a8), .op_b(op_b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] res;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int exp_lat);
    int lat;
    @(negedge clk);
    check("in_ready_before", in_ready, 1);
    op_a = v.a; op_b = v.b; sub = v.s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    @(negedge clk);
    check("result", result, v.res);
    check("cout", cout, v.co);
    check("ovf", ovf, v.ov);
    check("zero", zero, v.z);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int lat, prev, spacing_bad;
    logic seen;

    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};

    // reset state
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i], 8);

    // backpressure in DONE with operand pulses
    start_op(32'd3, 32'd4, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op_a = 32'hDEAD_0000 + i; op_b = 32'h1111; sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, 32'd7);
      check("bp_flags", {cout, ovf, zero}, 3'b000);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("bp_no_accept", in_ready, 1);

    // flush at counter == 3
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_idle", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; seen |= out_valid; end
    check("flush_no_out_valid", seen, 0);
    run_op('{32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0}, 8);

    // flush beats in_valid in IDLE
    @(negedge clk); flush = 1'b1; in_valid = 1'b1; op_a = 32'd1; op_b = 32'd1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    check("flush_vs_accept", in_ready, 1);

    // async reset mid-RUN
    start_op(32'd7, 32'd5, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    check("rstrun_in_ready", in_ready, 1);
    check("rstrun_out_valid", out_valid, 0);
    #3 rst_n = 1'b1;

    // async reset in DONE clears held result without a clock edge
    start_op(32'd7, 32'd5, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("rstdone_latency", lat, 8);
    @(negedge clk); #1 rst_n = 1'b0; #1;
    check("rstdone_out_valid", out_valid, 0);
    check("rstdone_in_ready", in_ready, 1);
    check("rstdone_result", result, 0);
    check("rstdone_cout", cout, 0);
    check("rstdone_zero", zero, 0);
    #1 rst_n = 1'b1;

    // WIDTH=8 single op
    @(negedge clk);
    check("w8_in_ready", in_ready8, 1);
    op_a8 = 8'h7F; op_b8 = 8'h01; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1; in_valid8 = 1'b0; op_a8 = 8'h00;
    lat = 0;
    while (!out_valid8 && lat < 10) begin @(posedge clk); #1; lat++; end
    check("w8_latency", lat, 2);
    check("w8_result", result8, 8'h80);
    check("w8_ovf", ovf8, 1);
    check("w8_cout", cout8, 0);
    check("w8_zero", zero8, 0);
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1; out_ready8 = 1'b0;
    check("w8_in_ready_after", in_ready8, 1);

    // WIDTH=8 back-to-back: accepts must be 4 cycles apart (idle, 2x run, done)
    @(negedge clk);
    op_a8 = 8'h7F; op_b8 = 8'h01; sub8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
    prev = -1; spacing_bad = 0; lat = 0;
    for (int i = 0; i < 16; i++) begin
      if (in_ready8) begin
        if (prev >= 0 && (i - prev) != 4) spacing_bad++;
        prev = i;
        lat++;
      end
      if (out_valid8) check("b2b_result", result8, 8'h80);
      @(negedge clk);
    end
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    check("b2b_spacing", spacing_bad, 0);
    check("b2b_accepts", lat, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

`default_nettype wire

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Multi-cycle add/subtract sequencer for the cpu_design datapath.
- Time-shares one instance of the team's 4-bit carry-lookahead slice (adder_4bits) across a WIDTH-bit operation, one nibble per clock, LSB nibble first.
- Valid/ready handshake on the operand side and on the result side; used where area matters more than latency.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8; N = WIDTH/4 nibble steps.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort; highest priority after rst_n
in_valid  input  1  operand request
in_ready  output  1  high only in IDLE
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B (two's complement)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum/difference
cout  output  1  carry out of MSB; for subtract, 1 = no borrow
ovf  output  1  signed overflow
zero  output  1  result == 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, nibble counter 0, carry register 0.
- Reset output values: in_ready=1, out_valid=0, result=0, cout=0, ovf=0, zero=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 at a clock edge is an accept: latch A=op_a, B'=(sub ? ~op_b : op_b), carry=sub, counter=0, go to RUN.
  - All operands are ignored outside IDLE.
- RUN:
  - Each cycle, the slice adds A[4k+3:4k] + B'[4k+3:4k] + carry, where k = counter.
  - The 4-bit sum is written into result[4k+3:4k], carry takes the slice co, and counter increments.
  - When counter == N-1, also latch cout = slice co, then go to DONE.
- Latency: the accept edge is E0. Nibble k is registered at edge E(k+1). out_valid rises after edge EN, i.e. N cycles after accept (8 for WIDTH=32).
- DONE:
  - out_valid=1. result, cout, ovf and zero are held stable until out_ready=1 at a clock edge, then go to IDLE.
  - A new operand cannot be accepted in the same cycle as the result is consumed; there is one IDLE cycle minimum between operations.
- ovf = (A[MSB] == B'[MSB]) && (result[MSB] != A[MSB]), computed from the latched operands and the final sum. It is valid only while out_valid=1.
- zero = (result == 0), valid only while out_valid=1.
- result upper nibbles are don't-care while in RUN. The bench checks outputs only when out_valid=1.
- flush=1 at an edge: go to IDLE from any state, out_valid=0, counter=0, and any in-flight or pending result is discarded. If flush and in_valid are high together in IDLE, flush wins and nothing is accepted.
- rst_n asserted mid-RUN or in DONE: immediate return to the reset state; the result is lost.
- Counter width: clog2(N). The counter never wraps past N-1.
- Exactly one adder slice instance; no WIDTH-wide adder is permitted.

Test Plan:
1. WIDTH=32: A=0x0000_0001, B=0xFFFF_FFFF, sub=0 -> result=0x0000_0000, cout=1, zero=1, ovf=0; out_valid asserted exactly 8 cycles after accept.
2. A=0x7FFF_FFFF, B=0x0000_0001, sub=0 -> result=0x8000_0000, cout=0, ovf=1, zero=0. Then A=0x8000_0000, B=0x8000_0000 -> result=0, cout=1, ovf=1, zero=1.
3. sub=1, A=5, B=7 -> result=0xFFFF_FFFE, cout=0, ovf=0. Then A=7, B=5 -> result=0x0000_0002, cout=1, ovf=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> in_ready=0, result/flags unchanged, no accept. Raising out_ready -> IDLE next cycle, in_ready=1.
5. Abort: flush at RUN counter=3 -> IDLE next edge, out_valid never rises, and the next operation (3+4) returns result=7 correctly. Repeat with rst_n pulsed low mid-RUN -> all outputs at reset values immediately, without waiting for a clock edge.
6. WIDTH=8: A=0x7F, B=0x01, sub=0 -> result=0x80, ovf=1, cout=0, out_valid 2 cycles after accept. Back-to-back operations with out_ready tied high -> one IDLE cycle between each.
